// File: rtl/pipeline_hazard_ctrl.sv
// Sequencing/hazard controller for a 5-stage pipeline: stalls, flushes and E-stage forwarding.
// Define HAZARD_PERF_CNT_EN to add stall-cycle and flush-event performance counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_ADDR_WIDTH     = 5,
    parameter int unsigned RESET_FLUSH_CYCLES = 4,
    parameter int unsigned MAX_MEM_WAIT       = 15
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs1D_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2D_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs1E_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2E_i,
    input  logic [REG_ADDR_WIDTH-1:0] rdE_i,
    input  logic [REG_ADDR_WIDTH-1:0] rdM_i,
    input  logic [REG_ADDR_WIDTH-1:0] rdW_i,
    input  logic                      result_srcE_i,
    input  logic                      reg_writeM_i,
    input  logic                      reg_writeW_i,
    input  logic                      pc_srcE_i,
    input  logic                      mem_reqM_i,
    input  logic                      mem_ready_i,
    output logic                      stallF_o,
    output logic                      stallD_o,
    output logic                      stallE_o,
    output logic                      stallM_o,
    output logic                      flushD_o,
    output logic                      flushE_o,
    output logic                      flushW_o,
    output logic [1:0]                forward_aE_o,
    output logic [1:0]                forward_bE_o,
    output logic                      mem_timeout_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]               stall_cycles_o,
    output logic [31:0]               flush_events_o
`endif
);

    localparam int unsigned CLR_W  = 4;
    localparam int unsigned WAIT_W = 8;
    localparam int unsigned FWD_W  = 2;

    localparam logic [CLR_W-1:0]  CLR_LAST = CLR_W'(RESET_FLUSH_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_MEM_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_SAT = '1;

    localparam logic [FWD_W-1:0] FWD_RF = 2'b00;
    localparam logic [FWD_W-1:0] FWD_W_RES = 2'b01;
    localparam logic [FWD_W-1:0] FWD_M_ALU = 2'b10;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CLR_W-1:0]    clr_q, clr_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                timeout_q, timeout_d;

    logic mem_stall_c;
    logic load_use_c;

    // A held memory access stalls from the first miss cycle until ready returns.
    assign mem_stall_c = ((state_q == ST_RUN) && mem_reqM_i && !mem_ready_i) ||
                         ((state_q == ST_WAIT) && !mem_ready_i);

    assign load_use_c = result_srcE_i && (rdE_i != '0) &&
                        ((rdE_i == rs1D_i) || (rdE_i == rs2D_i));

    function automatic logic [FWD_W-1:0] fwd_sel(
        input logic [REG_ADDR_WIDTH-1:0] rs,
        input logic                      wr_m,
        input logic [REG_ADDR_WIDTH-1:0] rd_m,
        input logic                      wr_w,
        input logic [REG_ADDR_WIDTH-1:0] rd_w
    );
        if (wr_m && (rd_m != '0) && (rd_m == rs)) begin
            return FWD_M_ALU;
        end
        if (wr_w && (rd_w != '0) && (rd_w == rs)) begin
            return FWD_W_RES;
        end
        return FWD_RF;
    endfunction

    // State and counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_CLEAR;
            clr_q     <= '0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_q     <= clr_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        wait_d  = wait_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_q == CLR_LAST) begin
                    state_d = ST_RUN;
                    clr_d   = '0;
                end else begin
                    clr_d = clr_q + CLR_W'(1);
                end
            end
            ST_RUN: begin
                if (mem_stall_c) begin
                    state_d = ST_WAIT;
                    wait_d  = WAIT_W'(1);
                end
            end
            ST_WAIT: begin
                if (!mem_ready_i) begin
                    wait_d = (wait_q == WAIT_SAT) ? wait_q : wait_q + WAIT_W'(1);
                end else begin
                    state_d = ST_RUN;
                    wait_d  = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                clr_d   = '0;
                wait_d  = '0;
            end
        endcase
        timeout_d = timeout_q | (wait_d == WAIT_MAX);
    end

    // Pipeline control outputs; memory stall outranks branch, branch outranks load-use.
    always_comb begin
        stallF_o     = 1'b0;
        stallD_o     = 1'b0;
        stallE_o     = 1'b0;
        stallM_o     = 1'b0;
        flushD_o     = 1'b0;
        flushE_o     = 1'b0;
        flushW_o     = 1'b0;
        forward_aE_o = FWD_RF;
        forward_bE_o = FWD_RF;
        case (state_q)
            ST_CLEAR: begin
                stallF_o = 1'b1;
                flushD_o = 1'b1;
                flushE_o = 1'b1;
                flushW_o = 1'b1;
            end
            ST_RUN, ST_WAIT: begin
                forward_aE_o = fwd_sel(rs1E_i, reg_writeM_i, rdM_i, reg_writeW_i, rdW_i);
                forward_bE_o = fwd_sel(rs2E_i, reg_writeM_i, rdM_i, reg_writeW_i, rdW_i);
                if (mem_stall_c) begin
                    stallF_o = 1'b1;
                    stallD_o = 1'b1;
                    stallE_o = 1'b1;
                    stallM_o = 1'b1;
                    flushW_o = 1'b1;
                end else if (pc_srcE_i) begin
                    flushD_o = 1'b1;
                    flushE_o = 1'b1;
                end else if (load_use_c) begin
                    stallF_o = 1'b1;
                    stallD_o = 1'b1;
                    flushE_o = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign mem_timeout_o = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    localparam int unsigned PERF_W = 32;

    logic [PERF_W-1:0] stall_cnt_q;
    logic [PERF_W-1:0] flush_cnt_q;

    // Saturating event counters, idle during the post-reset clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (state_q != ST_CLEAR) begin
            if (stallF_o && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + PERF_W'(1);
            end
            if (flushE_o && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + PERF_W'(1);
            end
        end
    end

    assign stall_cycles_o = stall_cnt_q;
    assign flush_events_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: vector table, multi-cycle sequences and randomized traffic
// checked against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned AW   = 5;
    localparam int          RFC  = 4;
    localparam int          MAXW = 15;

    // Control field order: stallF stallD stallE stallM flushD flushE flushW
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_CLR  = 7'b1000111;
    localparam logic [6:0] C_MISS = 7'b1111001;
    localparam logic [6:0] C_BR   = 7'b0000110;
    localparam logic [6:0] C_LU   = 7'b1100010;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic          ld, wM, wW, pc, req, rdy;
    logic          stF, stD, stE, stM, flD, flE, flW, tmo;
    logic [1:0]    fa, fb;
    logic [11:0]   dut_vec;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_events;
    longint      m_stall = 0;
    longint      m_flush = 0;
`endif

    pipeline_hazard_ctrl #(
        .REG_ADDR_WIDTH    (AW),
        .RESET_FLUSH_CYCLES(RFC),
        .MAX_MEM_WAIT      (MAXW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .rs1D_i       (rs1D),
        .rs2D_i       (rs2D),
        .rs1E_i       (rs1E),
        .rs2E_i       (rs2E),
        .rdE_i        (rdE),
        .rdM_i        (rdM),
        .rdW_i        (rdW),
        .result_srcE_i(ld),
        .reg_writeM_i (wM),
        .reg_writeW_i (wW),
        .pc_srcE_i    (pc),
        .mem_reqM_i   (req),
        .mem_ready_i  (rdy),
        .stallF_o     (stF),
        .stallD_o     (stD),
        .stallE_o     (stE),
        .stallM_o     (stM),
        .flushD_o     (flD),
        .flushE_o     (flE),
        .flushW_o     (flW),
        .forward_aE_o (fa),
        .forward_bE_o (fb),
        .mem_timeout_o(tmo)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles_o(stall_cycles),
        .flush_events_o(flush_events)
`endif
    );

    always #5 clk = ~clk;

    assign dut_vec = {stF, stD, stE, stM, flD, flE, flW, fa, fb, tmo};

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state: clear cycles left, waiting flag, wait length, sticky timeout.
    int m_clr  = RFC;
    bit m_wait = 1'b0;
    int m_wcnt = 0;
    bit m_tmo  = 1'b0;

    function automatic logic [1:0] ref_fwd(input logic [AW-1:0] rs);
        if (wM && rdM != '0 && rdM == rs) return 2'b10;
        if (wW && rdW != '0 && rdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit ref_miss();
        return m_wait ? !rdy : (req && !rdy);
    endfunction

    function automatic logic [11:0] model_vec();
        logic [6:0] ctl;
        logic [1:0] ea;
        logic [1:0] eb;
        bit         lu;
        ctl = C_NONE;
        ea  = 2'b00;
        eb  = 2'b00;
        lu  = ld && rdE != '0 && (rdE == rs1D || rdE == rs2D);
        if (m_clr > 0) begin
            ctl = C_CLR;
        end else begin
            if (ref_miss()) ctl = C_MISS;
            else if (pc)    ctl = C_BR;
            else if (lu)    ctl = C_LU;
            ea = ref_fwd(rs1E);
            eb = ref_fwd(rs2E);
        end
        return {ctl, ea, eb, m_tmo};
    endfunction

    always @(posedge clk) begin : model_update
        logic [11:0] e;
        e = model_vec();
        if (rst) begin
            m_clr  = RFC;
            m_wait = 1'b0;
            m_wcnt = 0;
            m_tmo  = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
            m_stall = 0;
            m_flush = 0;
`endif
        end else if (m_clr > 0) begin
            m_clr = m_clr - 1;
        end else begin
`ifdef HAZARD_PERF_CNT_EN
            if (e[11]) m_stall = m_stall + 1;
            if (e[6])  m_flush = m_flush + 1;
`endif
            if (ref_miss()) begin
                m_wcnt = m_wait ? ((m_wcnt < 255) ? m_wcnt + 1 : 255) : 1;
                m_wait = 1'b1;
                if (m_wcnt == MAXW) m_tmo = 1'b1;
            end else begin
                m_wait = 1'b0;
                m_wcnt = 0;
            end
        end
    end

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b required %b (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic idle();
        {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW} = '0;
        {ld, wM, wW, pc, req, rdy} = '0;
    endtask

    // Checks the current cycle's combinational outputs, then advances to the next cycle.
    task automatic cyc(input string name, input logic [11:0] exp);
        #1;
        check(name, dut_vec, exp);
        @(negedge clk);
    endtask

    typedef struct {
        string      name;
        logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
        logic       ld, wM, wW, pc, req, rdy;
        logic [6:0] ctl;
        logic [1:0] fa, fb;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string n,
                       input logic [4:0] a1D, a2D, a1E, a2E, aE, aM, aW,
                       input logic il, iwm, iww, ipc, ireq, irdy,
                       input logic [6:0] c, input logic [1:0] xa, xb);
        vec_t v;
        v.name = n;
        v.rs1D = a1D; v.rs2D = a2D; v.rs1E = a1E; v.rs2E = a2E;
        v.rdE = aE; v.rdM = aM; v.rdW = aW;
        v.ld = il; v.wM = iwm; v.wW = iww; v.pc = ipc; v.req = ireq; v.rdy = irdy;
        v.ctl = c; v.fa = xa; v.fb = xb;
        tbl.push_back(v);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        //   name          rs1D rs2D rs1E rs2E rdE rdM rdW ld wM wW pc rq rdy ctl     fa     fb
        add("idle",        0,   0,   0,   0,   0,  0,  0,  0, 0, 0, 0, 0, 0, C_NONE, 2'b00, 2'b00);
        add("lu_rs1",      5,   0,   0,   0,   5,  0,  0,  1, 0, 0, 0, 0, 0, C_LU,   2'b00, 2'b00);
        add("lu_x0",       0,   0,   0,   0,   0,  0,  0,  1, 0, 0, 0, 0, 0, C_NONE, 2'b00, 2'b00);
        add("lu_rs2",      0,   12,  0,   0,   12, 0,  0,  1, 0, 0, 0, 0, 0, C_LU,   2'b00, 2'b00);
        add("lu_vs_br",    0,   7,   0,   0,   7,  0,  0,  1, 0, 0, 1, 0, 0, C_BR,   2'b00, 2'b00);
        add("br_only",     0,   0,   0,   0,   0,  0,  0,  0, 0, 0, 1, 0, 0, C_BR,   2'b00, 2'b00);
        add("ld_nomatch",  5,   6,   0,   0,   4,  0,  0,  1, 0, 0, 0, 0, 0, C_NONE, 2'b00, 2'b00);
        add("fwd_a_m",     0,   0,   9,   0,   0,  9,  9,  0, 1, 1, 0, 0, 0, C_NONE, 2'b10, 2'b00);
        add("fwd_a_w",     0,   0,   9,   0,   0,  9,  9,  0, 0, 1, 0, 0, 0, C_NONE, 2'b01, 2'b00);
        add("fwd_x0",      0,   0,   0,   0,   0,  0,  0,  0, 1, 1, 0, 0, 0, C_NONE, 2'b00, 2'b00);
        add("fwd_b_m",     0,   0,   0,   3,   0,  3,  3,  0, 1, 1, 0, 0, 0, C_NONE, 2'b00, 2'b10);
        add("fwd_mix",     0,   0,   4,   6,   0,  6,  4,  0, 1, 1, 0, 0, 0, C_NONE, 2'b01, 2'b10);
        add("mem_hit",     0,   0,   0,   0,   0,  0,  0,  0, 0, 0, 0, 1, 1, C_NONE, 2'b00, 2'b00);
        add("rdy_no_req",  0,   0,   0,   0,   0,  0,  0,  0, 0, 0, 0, 0, 1, C_NONE, 2'b00, 2'b00);

        // Reset and post-reset clear; forwarding-eligible inputs must still give 00.
        @(negedge clk);
        rst = 1'b0;
        rs1E = 9; rdM = 9; wM = 1'b1;
        for (int i = 0; i < RFC; i++) cyc("clear", {C_CLR, 4'b0000, 1'b0});
        cyc("run_after_clear", {C_NONE, 2'b10, 2'b00, 1'b0});
        idle();
        cyc("run_idle", {C_NONE, 4'b0000, 1'b0});

        foreach (tbl[i]) begin
            rs1D = tbl[i].rs1D; rs2D = tbl[i].rs2D; rs1E = tbl[i].rs1E; rs2E = tbl[i].rs2E;
            rdE = tbl[i].rdE; rdM = tbl[i].rdM; rdW = tbl[i].rdW;
            ld = tbl[i].ld; wM = tbl[i].wM; wW = tbl[i].wW; pc = tbl[i].pc;
            req = tbl[i].req; rdy = tbl[i].rdy;
            cyc(tbl[i].name, {tbl[i].ctl, tbl[i].fa, tbl[i].fb, 1'b0});
        end
        idle();

        // Three-cycle miss then release.
        req = 1'b1;
        for (int i = 0; i < 3; i++) cyc("miss3", {C_MISS, 4'b0000, 1'b0});
        rdy = 1'b1;
        cyc("miss3_release", {C_NONE, 4'b0000, 1'b0});
        idle();
        cyc("miss3_after", {C_NONE, 4'b0000, 1'b0});

        // Miss and branch together: stall first, branch flush on release.
        req = 1'b1; pc = 1'b1;
        cyc("miss_br_stall", {C_MISS, 4'b0000, 1'b0});
        rdy = 1'b1;
        cyc("miss_br_release", {C_BR, 4'b0000, 1'b0});
        idle();

        // Long miss drives the sticky timeout.
        req = 1'b1;
        for (int k = 1; k <= 20; k++) cyc("timeout_wait", {C_MISS, 4'b0000, (k > MAXW) ? 1'b1 : 1'b0});
        rdy = 1'b1;
        cyc("timeout_release", {C_NONE, 4'b0000, 1'b1});
        idle();
        cyc("timeout_sticky", {C_NONE, 4'b0000, 1'b1});

        // Reset during a wait, then reset again mid-clear.
        req = 1'b1;
        cyc("rst_pre_wait", {C_MISS, 4'b0000, 1'b1});
        rst = 1'b1;
        cyc("rst_in_wait", {C_MISS, 4'b0000, 1'b1});
        rst = 1'b0;
        cyc("rst_clear1", {C_CLR, 4'b0000, 1'b0});
        rst = 1'b1;
        cyc("rst_clear2", {C_CLR, 4'b0000, 1'b0});
        rst = 1'b0;
        for (int i = 0; i < RFC; i++) cyc("reclear", {C_CLR, 4'b0000, 1'b0});
        cyc("reclear_run_miss", {C_MISS, 4'b0000, 1'b0});
        rdy = 1'b1;
        cyc("reclear_release", {C_NONE, 4'b0000, 1'b0});
        idle();

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 299) == 0);
            rs1D = AW'($urandom_range(0, 3));
            rs2D = AW'($urandom_range(0, 3));
            rs1E = AW'($urandom_range(0, 3));
            rs2E = AW'($urandom_range(0, 3));
            rdE  = AW'($urandom_range(0, 3));
            rdM  = AW'($urandom_range(0, 3));
            rdW  = AW'($urandom_range(0, 3));
            ld   = ($urandom_range(0, 1) == 0);
            wM   = ($urandom_range(0, 1) == 0);
            wW   = ($urandom_range(0, 1) == 0);
            pc   = ($urandom_range(0, 4) == 0);
            req  = ($urandom_range(0, 3) == 0);
            rdy  = (i % 500 < 40) ? 1'b0 : ($urandom_range(0, 9) < 4);
            cyc("random", model_vec());
        end
        rst = 1'b0;
        idle();
        @(negedge clk);

`ifdef HAZARD_PERF_CNT_EN
        n_checks++;
        if (stall_cycles !== 32'(m_stall)) begin
            n_err++;
            $display("FAIL stall_cycles: got %0d required %0d", stall_cycles, m_stall);
        end
        n_checks++;
        if (flush_events !== 32'(m_flush)) begin
            n_err++;
            $display("FAIL flush_events: got %0d required %0d", flush_events, m_flush);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
